// File: rtl/abro_stim_driver.sv
// ---------------------------------------------------------------------------
// abro_stim_driver
// Stimulus/initiator for the a/b -> z handshake in front of an ABRO-style
// responder. Issues single-cycle a/b pulses in a programmable order with a
// programmable gap, waits (bounded) for the z acknowledge, and reports a
// per-transaction pass/fail plus a saturating pass count.
//
// Ports:
//   clk        rising-edge clock
//   reset      synchronous, active-high reset
//   start      request a transaction (honoured only in IDLE)
//   mode[1:0]  00 a->b, 01 b->a, 10 a&b together, 11 a only (expect no z)
//   gap        idle cycles between first and second pulse (modes 00/01)
//   z          acknowledge from the responder
//   a, b       registered event pulses
//   busy       high in every state except IDLE
//   done       one-cycle pulse in the final (DONE) cycle of a transaction
//   pass       result of the last transaction, held until the next done
//   early_err  sticky: z seen before the second pulse was issued
//   pass_cnt   saturating count of passing transactions
// ---------------------------------------------------------------------------
module abro_stim_driver #(
    parameter int unsigned GAP_W   = 4,
    parameter int unsigned TIMEOUT = 8,
    parameter int unsigned CNT_W   = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [1:0]       mode,
    input  logic [GAP_W-1:0] gap,
    input  logic             z,
    output logic             a,
    output logic             b,
    output logic             busy,
    output logic             done,
    output logic             pass,
    output logic             early_err,
    output logic [CNT_W-1:0] pass_cnt
);

    // Timeout counter is sized for the full legal TIMEOUT range (1..255).
    localparam int unsigned TO_W = 8;

    localparam logic [1:0] MODE_AB    = 2'b00;
    localparam logic [1:0] MODE_BA    = 2'b01;
    localparam logic [1:0] MODE_SIM   = 2'b10;
    localparam logic [1:0] MODE_AONLY = 2'b11;

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_FIRST  = 3'd1,
        S_GAP    = 3'd2,
        S_SECOND = 3'd3,
        S_WAIT_Z = 3'd4,
        S_DONE   = 3'd5
    } state_e;

    state_e             state_q, state_d;
    logic [1:0]         mode_q, mode_d;
    logic [GAP_W-1:0]   gap_q, gap_d;
    logic [GAP_W-1:0]   gap_cnt_q, gap_cnt_d;
    logic [TO_W-1:0]    to_cnt_q, to_cnt_d;
    logic               a_q, a_d;
    logic               b_q, b_d;
    logic               busy_q, busy_d;
    logic               done_q, done_d;
    logic               pass_q, pass_d;
    logic               early_err_q, early_err_d;
    logic [CNT_W-1:0]   pass_cnt_q, pass_cnt_d;
    logic               result_c;

    // State and output registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= S_IDLE;
            mode_q      <= 2'b00;
            gap_q       <= '0;
            gap_cnt_q   <= '0;
            to_cnt_q    <= '0;
            a_q         <= 1'b0;
            b_q         <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            pass_q      <= 1'b0;
            early_err_q <= 1'b0;
            pass_cnt_q  <= '0;
        end else begin
            state_q     <= state_d;
            mode_q      <= mode_d;
            gap_q       <= gap_d;
            gap_cnt_q   <= gap_cnt_d;
            to_cnt_q    <= to_cnt_d;
            a_q         <= a_d;
            b_q         <= b_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            pass_q      <= pass_d;
            early_err_q <= early_err_d;
            pass_cnt_q  <= pass_cnt_d;
        end
    end

    // Next-state logic; outputs are decoded from the next state so the
    // registered pulses line up with the cycle spent in that state.
    always_comb begin
        state_d     = state_q;
        mode_d      = mode_q;
        gap_d       = gap_q;
        gap_cnt_d   = gap_cnt_q;
        to_cnt_d    = to_cnt_q;
        early_err_d = early_err_q;
        pass_d      = pass_q;
        pass_cnt_d  = pass_cnt_q;
        result_c    = 1'b0;
        a_d         = 1'b0;
        b_d         = 1'b0;
        busy_d      = 1'b0;
        done_d      = 1'b0;

        unique case (state_q)
            S_IDLE: begin
                if (start) begin
                    mode_d  = mode;
                    gap_d   = gap;
                    state_d = S_FIRST;
                end
            end

            S_FIRST: begin
                if (z) begin
                    // Acknowledge before the sequence finished: abort.
                    early_err_d = 1'b1;
                    state_d     = S_DONE;
                end else if (mode_q == MODE_SIM || mode_q == MODE_AONLY) begin
                    to_cnt_d = '0;
                    state_d  = S_WAIT_Z;
                end else if (gap_q != '0) begin
                    gap_cnt_d = gap_q;
                    state_d   = S_GAP;
                end else begin
                    state_d = S_SECOND;
                end
            end

            S_GAP: begin
                if (z) begin
                    early_err_d = 1'b1;
                    state_d     = S_DONE;
                end else if (gap_cnt_q == GAP_W'(1)) begin
                    state_d = S_SECOND;
                end else begin
                    gap_cnt_d = gap_cnt_q - GAP_W'(1);
                end
            end

            S_SECOND: begin
                if (z) begin
                    early_err_d = 1'b1;
                    state_d     = S_DONE;
                end else begin
                    to_cnt_d = '0;
                    state_d  = S_WAIT_Z;
                end
            end

            S_WAIT_Z: begin
                // z takes priority over an expiring timeout.
                if (z) begin
                    result_c = (mode_q != MODE_AONLY);
                    state_d  = S_DONE;
                end else if (to_cnt_q == TO_W'(TIMEOUT - 1)) begin
                    result_c = (mode_q == MODE_AONLY);
                    state_d  = S_DONE;
                end else begin
                    to_cnt_d = to_cnt_q + TO_W'(1);
                end
            end

            S_DONE: begin
                state_d = S_IDLE;
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase

        // Entering DONE: publish the result and bump the saturating count.
        if (state_d == S_DONE && state_q != S_DONE) begin
            pass_d = result_c;
            if (result_c && pass_cnt_q != {CNT_W{1'b1}}) begin
                pass_cnt_d = pass_cnt_q + CNT_W'(1);
            end
        end

        // mode_d equals the incoming mode on the IDLE->FIRST transition.
        a_d = (state_d == S_FIRST  && mode_d != MODE_BA) ||
              (state_d == S_SECOND && mode_d == MODE_BA);
        b_d = (state_d == S_FIRST  && (mode_d == MODE_BA || mode_d == MODE_SIM)) ||
              (state_d == S_SECOND && mode_d == MODE_AB);
        busy_d = (state_d != S_IDLE);
        done_d = (state_d == S_DONE);
    end

    assign a         = a_q;
    assign b         = b_q;
    assign busy      = busy_q;
    assign done      = done_q;
    assign pass      = pass_q;
    assign early_err = early_err_q;
    assign pass_cnt  = pass_cnt_q;

endmodule

// File: tb/tb_abro_stim_driver.sv
// ---------------------------------------------------------------------------
// tb_abro_stim_driver
// Directed bench for abro_stim_driver. Cycle n is the interval after rising
// edge n; edge 0 is the edge that samples start. Inputs change and outputs
// are sampled 1 time unit after each rising edge. A second instance with
// CNT_W=2 shares the inputs and is used for the saturation check.
// ---------------------------------------------------------------------------
module tb_abro_stim_driver;

    localparam int unsigned GAP_W = 4;

    logic             clk;
    logic             reset;
    logic             start;
    logic [1:0]       mode;
    logic [GAP_W-1:0] gap;
    logic             z;

    logic       a, b, busy, done, pass, early_err;
    logic [7:0] pass_cnt;
    logic       s_a, s_b, s_busy, s_done, s_pass, s_early_err;
    logic [1:0] s_pass_cnt;

    int n_total = 0;
    int n_pass  = 0;

    abro_stim_driver #(.GAP_W(GAP_W), .TIMEOUT(8), .CNT_W(8)) u_dut (
        .clk(clk), .reset(reset), .start(start), .mode(mode), .gap(gap), .z(z),
        .a(a), .b(b), .busy(busy), .done(done), .pass(pass),
        .early_err(early_err), .pass_cnt(pass_cnt)
    );

    abro_stim_driver #(.GAP_W(GAP_W), .TIMEOUT(8), .CNT_W(2)) u_sat (
        .clk(clk), .reset(reset), .start(start), .mode(mode), .gap(gap), .z(z),
        .a(s_a), .b(s_b), .busy(s_busy), .done(s_done), .pass(s_pass),
        .early_err(s_early_err), .pass_cnt(s_pass_cnt)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #100000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp) $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        else n_pass++;
    endtask

    // Passing mode-10 transaction with z returned in the first WAIT_Z cycle.
    task automatic run_sim_pass();
        start = 1'b1; mode = 2'b10; gap = '0;
        tick();                 // cycle 1: FIRST
        start = 1'b0;
        tick();                 // cycle 2: WAIT_Z
        z = 1'b1;
        tick();                 // cycle 3: DONE
        z = 1'b0;
    endtask

    initial begin
        logic seen;
        reset = 1'b1; start = 1'b0; mode = 2'b00; gap = '0; z = 1'b0;
        tick(); tick();
        reset = 1'b0;
        check("rst_a",    32'(a), 32'd0);
        check("rst_b",    32'(b), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_pass", 32'(pass), 32'd0);
        check("rst_eerr", 32'(early_err), 32'd0);
        check("rst_cnt",  32'(pass_cnt), 32'd0);

        // Mode 00, gap 2: a in cycle 1, b in cycle 4, z in cycle 5, done in 6.
        start = 1'b1; mode = 2'b00; gap = 4'd2;
        tick();
        start = 1'b0;
        check("ab_c1_a", 32'(a), 32'd1);
        check("ab_c1_b", 32'(b), 32'd0);
        check("ab_c1_busy", 32'(busy), 32'd1);
        tick();
        check("ab_c2_ab", 32'({a, b}), 32'd0);
        tick();
        check("ab_c3_ab", 32'({a, b}), 32'd0);
        tick();
        check("ab_c4_ab", 32'({a, b}), 32'b01);
        tick();
        check("ab_c5_ab", 32'({a, b}), 32'd0);
        check("ab_c5_done", 32'(done), 32'd0);
        z = 1'b1;
        tick();
        z = 1'b0;
        check("ab_c6_done", 32'(done), 32'd1);
        check("ab_c6_busy", 32'(busy), 32'd1);
        check("ab_c6_pass", 32'(pass), 32'd1);
        check("ab_c6_cnt",  32'(pass_cnt), 32'd1);
        check("ab_c6_eerr", 32'(early_err), 32'd0);
        tick();
        check("ab_c7_done", 32'(done), 32'd0);
        check("ab_c7_busy", 32'(busy), 32'd0);
        check("ab_c7_pass", 32'(pass), 32'd1);

        // Mode 10: a and b together in cycle 1 only.
        start = 1'b1; mode = 2'b10; gap = 4'd3;
        tick();
        start = 1'b0;
        check("sim_c1_ab", 32'({a, b}), 32'b11);
        tick();
        check("sim_c2_ab", 32'({a, b}), 32'd0);
        z = 1'b1;
        tick();
        z = 1'b0;
        check("sim_done", 32'(done), 32'd1);
        check("sim_pass", 32'(pass), 32'd1);
        check("sim_cnt",  32'(pass_cnt), 32'd2);
        tick();

        // Mode 01, gap 0: b in cycle 1, a in cycle 2.
        start = 1'b1; mode = 2'b01; gap = 4'd0;
        tick();
        start = 1'b0;
        check("ba_c1_ab", 32'({a, b}), 32'b01);
        tick();
        check("ba_c2_ab", 32'({a, b}), 32'b10);
        tick();
        check("ba_c3_ab", 32'({a, b}), 32'd0);
        z = 1'b1;
        tick();
        z = 1'b0;
        check("ba_done", 32'(done), 32'd1);
        check("ba_pass", 32'(pass), 32'd1);
        check("ba_cnt",  32'(pass_cnt), 32'd3);
        tick();

        // Timeout, mode 00 gap 0: WAIT_Z spans cycles 3..10, DONE in cycle 11.
        start = 1'b1; mode = 2'b00; gap = 4'd0;
        tick();
        start = 1'b0;
        for (int i = 0; i < 9; i++) tick();
        check("to_c10_done", 32'(done), 32'd0);
        check("to_c10_busy", 32'(busy), 32'd1);
        tick();
        check("to_c11_done", 32'(done), 32'd1);
        check("to_c11_pass", 32'(pass), 32'd0);
        check("to_c11_cnt",  32'(pass_cnt), 32'd3);
        tick();

        // Mode 11, no z: DONE in cycle 10 with pass=1.
        start = 1'b1; mode = 2'b11; gap = 4'd0;
        tick();
        start = 1'b0;
        check("ao_c1_ab", 32'({a, b}), 32'b10);
        for (int i = 0; i < 8; i++) tick();
        check("ao_c9_done", 32'(done), 32'd0);
        tick();
        check("ao_c10_done", 32'(done), 32'd1);
        check("ao_c10_pass", 32'(pass), 32'd1);
        check("ao_c10_cnt",  32'(pass_cnt), 32'd4);
        tick();

        // Early z during GAP (mode 00, gap 5): z in cycle 3 -> DONE in cycle 4.
        start = 1'b1; mode = 2'b00; gap = 4'd5;
        tick();
        start = 1'b0;
        tick();
        tick();
        z = 1'b1;
        tick();
        z = 1'b0;
        check("ez_done", 32'(done), 32'd1);
        check("ez_pass", 32'(pass), 32'd0);
        check("ez_eerr", 32'(early_err), 32'd1);
        check("ez_cnt",  32'(pass_cnt), 32'd4);
        seen = b;
        for (int i = 0; i < 8; i++) begin
            tick();
            seen = seen | b;
        end
        check("ez_no_b", 32'(seen), 32'd0);
        check("ez_sticky", 32'(early_err), 32'd1);

        // start held through FIRST/WAIT_Z/DONE is ignored: one transaction only.
        start = 1'b1; mode = 2'b10; gap = '0;
        tick();                 // cycle 1
        tick();                 // cycle 2: WAIT_Z
        z = 1'b1;
        tick();                 // cycle 3: DONE, start still high
        z = 1'b0;
        check("ign_done", 32'(done), 32'd1);
        check("ign_cnt",  32'(pass_cnt), 32'd5);
        tick();                 // cycle 4
        start = 1'b0;
        check("ign_c4_busy", 32'(busy), 32'd0);
        seen = 1'b0;
        for (int i = 0; i < 6; i++) begin
            tick();
            seen = seen | a | b | busy;
        end
        check("ign_no_2nd", 32'(seen), 32'd0);

        // Reset in the middle of GAP.
        start = 1'b1; mode = 2'b00; gap = 4'd4;
        tick();
        start = 1'b0;
        tick();
        check("rg_busy_pre", 32'(busy), 32'd1);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        check("rg_a",    32'(a), 32'd0);
        check("rg_b",    32'(b), 32'd0);
        check("rg_busy", 32'(busy), 32'd0);
        check("rg_done", 32'(done), 32'd0);
        check("rg_pass", 32'(pass), 32'd0);
        check("rg_cnt",  32'(pass_cnt), 32'd0);
        check("rg_eerr", 32'(early_err), 32'd0);
        seen = 1'b0;
        for (int i = 0; i < 8; i++) begin
            tick();
            seen = seen | done | busy;
        end
        check("rg_no_done", 32'(seen), 32'd0);

        // Saturation on the CNT_W=2 instance: 1, 2, 3, 3.
        run_sim_pass();
        check("sat_1", 32'(s_pass_cnt), 32'd1);
        tick();
        run_sim_pass();
        check("sat_2", 32'(s_pass_cnt), 32'd2);
        tick();
        run_sim_pass();
        check("sat_3", 32'(s_pass_cnt), 32'd3);
        tick();
        run_sim_pass();
        check("sat_4", 32'(s_pass_cnt), 32'd3);
        check("sat_main_cnt", 32'(pass_cnt), 32'd4);
        tick();

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
